// File: rtl/shared_divider_pkg.sv
// Shared-divider package: FSM state encoding, op-select constants, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shared_divider_pkg;

    localparam int DEFAULT_THREADS   = 4;
    localparam int DEFAULT_DATA_BITS = 8;

    // Per-thread op select: which half of the divide result is returned.
    localparam logic OP_QUOTIENT  = 1'b0;
    localparam logic OP_REMAINDER = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/shared_divider_scheduler_rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping modulo THREADS.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: i_req request vector, i_ptr search start, o_grant one-hot winner,
//        o_idx encoded winner, o_any any request present.
module rr_pick #(
    parameter int THREADS = 4,
    parameter int PTR_W   = $clog2(THREADS)
) (
    input  logic [THREADS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [THREADS-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    logic [THREADS-1:0]   w_mask;
    logic [2*THREADS-1:0] w_dbl;
    logic                 w_found;

    // Lower copy keeps only requests at or above the pointer; the upper,
    // unmasked copy supplies the wrapped-around candidates.
    always_comb begin
        for (int i = 0; i < THREADS; i++) begin
            w_mask[i] = (PTR_W'(i) >= i_ptr);
        end
    end

    assign w_dbl = {i_req, i_req & w_mask};

    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < 2*THREADS; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                o_idx   = PTR_W'(i % THREADS);
            end
        end
    end

    assign o_any   = |i_req;
    assign o_grant = o_any ? (THREADS'(1) << o_idx) : '0;

endmodule

// File: rtl/shared_divider_scheduler.sv
// One iterative restoring divider shared round-robin between THREADS thread ALUs.
// Latency: DATA_BITS+2 cycles from the IDLE sampling cycle to the done cycle
//          (2 cycles for rt==0 / rs<rt when DIVIDER_EARLY_OUT_EN is defined).
// Backpressure: losers hold req and wait; one grant per IDLE visit, no timeout.
// Ports: clk, reset (async active-high); req/op/rs/rt per-thread requests;
//        done one-hot one-cycle completion; result quotient or remainder; busy != IDLE.
// Build option: DIVIDER_EARLY_OUT_EN skips iteration for trivially-known results.
module shared_divider_scheduler
    import shared_divider_pkg::*;
#(
    parameter int THREADS   = DEFAULT_THREADS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [THREADS-1:0]             req,
    input  logic [THREADS-1:0]             op,
    input  logic [THREADS*DATA_BITS-1:0]   rs,
    input  logic [THREADS*DATA_BITS-1:0]   rt,
    output logic [THREADS-1:0]             done,
    output logic [DATA_BITS-1:0]           result,
    output logic                           busy
);

    localparam int PTR_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    state_t               r_state,    w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr,   w_rr_ptr_nxt;
    logic [PTR_W-1:0]     r_win,      w_win_nxt;
    logic [THREADS-1:0]   r_win_oh,   w_win_oh_nxt;
    logic                 r_op,       w_op_nxt;
    logic [DATA_BITS-1:0] r_dq,       w_dq_nxt;     // dividend in, quotient out
    logic [DATA_BITS-1:0] r_dvs,      w_dvs_nxt;
    logic [DATA_BITS:0]   r_rem,      w_rem_nxt;    // one spare bit so the compare never overflows
    logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
    logic [THREADS-1:0]   r_done,     w_done_nxt;
    logic [DATA_BITS-1:0] r_result,   w_result_nxt;

    logic [THREADS-1:0]   w_grant;
    logic [PTR_W-1:0]     w_idx;
    logic                 w_any;
    logic [DATA_BITS-1:0] w_sel_rs;
    logic [DATA_BITS-1:0] w_sel_rt;
    logic                 w_sel_op;

    logic [DATA_BITS:0]   w_rem_sh;
    logic                 w_ge;
    logic [DATA_BITS:0]   w_rem_iter;
    logic [DATA_BITS-1:0] w_dq_iter;

    rr_pick #(
        .THREADS (THREADS),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_rs = rs[w_idx*DATA_BITS +: DATA_BITS];
    assign w_sel_rt = rt[w_idx*DATA_BITS +: DATA_BITS];
    assign w_sel_op = op[w_idx];

    // One restoring step: bring in the next dividend MSB, trial-subtract.
    // With a zero divisor the compare always succeeds, giving all-ones
    // quotient and remainder == dividend without any special case.
    assign w_rem_sh   = {r_rem[DATA_BITS-1:0], r_dq[DATA_BITS-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_iter = w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
    assign w_dq_iter  = {r_dq[DATA_BITS-2:0], w_ge};

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_win_nxt    = r_win;
        w_win_oh_nxt = r_win_oh;
        w_op_nxt     = r_op;
        w_dq_nxt     = r_dq;
        w_dvs_nxt    = r_dvs;
        w_rem_nxt    = r_rem;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = '0;
        w_result_nxt = r_result;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_win_nxt    = w_idx;
                    w_win_oh_nxt = w_grant;
                    w_op_nxt     = w_sel_op;
                    w_dq_nxt     = w_sel_rs;
                    w_dvs_nxt    = w_sel_rt;
                    w_rem_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ITERATE;
`ifdef DIVIDER_EARLY_OUT_EN
                    // Result is known without iterating: quotient is all ones
                    // (zero divisor) or zero (dividend smaller), remainder is rs.
                    if ((w_sel_rt == '0) || (w_sel_rs < w_sel_rt)) begin
                        w_state_nxt  = DONE;
                        w_done_nxt   = w_grant;
                        w_result_nxt = (w_sel_op == OP_REMAINDER) ? w_sel_rs :
                                       ((w_sel_rt == '0) ? '1 : '0);
                    end
`endif
                end
            end

            ITERATE: begin
                w_rem_nxt = w_rem_iter;
                w_dq_nxt  = w_dq_iter;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                    // done and result are registered so they line up with DONE.
                    w_state_nxt  = DONE;
                    w_done_nxt   = r_win_oh;
                    w_result_nxt = (r_op == OP_REMAINDER) ? w_rem_iter[DATA_BITS-1:0] : w_dq_iter;
                end
            end

            DONE: begin
                w_rr_ptr_nxt = (r_win == PTR_W'(THREADS - 1)) ? '0 : (r_win + 1'b1);
                w_state_nxt  = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_win_oh <= '0;
            r_op     <= 1'b0;
            r_dq     <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_win    <= w_win_nxt;
            r_win_oh <= w_win_oh_nxt;
            r_op     <= w_op_nxt;
            r_dq     <= w_dq_nxt;
            r_dvs    <= w_dvs_nxt;
            r_rem    <= w_rem_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_shared_divider_scheduler.sv
// Directed bench for shared_divider_scheduler: hand-computed quotients/remainders,
// grant order, latency in clock edges, busy/done framing and mid-operation reset.
// Expected latency is in edges after the request is driven: DATA_BITS+1 normally, 1 for early-out.
module tb_shared_divider_scheduler;

    localparam int T  = 4;
    localparam int DB = 8;
    localparam int EDGES_FULL = DB + 1;
`ifdef DIVIDER_EARLY_OUT_EN
    localparam int EDGES_EO = 1;
`else
    localparam int EDGES_EO = DB + 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [T-1:0]    req;
    logic [T-1:0]    op;
    logic [T*DB-1:0] rs;
    logic [T*DB-1:0] rt;
    logic [T-1:0]    done;
    logic [DB-1:0]   result;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_divider_scheduler #(
        .THREADS   (T),
        .DATA_BITS (DB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_thread(input int t, input logic o, input logic [DB-1:0] a, input logic [DB-1:0] b);
        op[t]            = o;
        rs[t*DB +: DB]   = a;
        rt[t*DB +: DB]   = b;
        req[t]           = 1'b1;
    endtask

    // Called #1 after an edge; counts edges until done rises, checks the
    // completion, then drops req on the edge that ends the done cycle.
    task automatic wait_done(input string tag, input int t, input int exp_edges, input logic [DB-1:0] exp_res);
        int         n       = 0;
        logic       busy_ok = 1'b1;
        logic [T-1:0] exp_oh;
        exp_oh = T'(1) << t;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done != '0) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check_eq({tag, ".done"},    32'(done),   32'(exp_oh));
        check_eq({tag, ".edges"},   32'(n),      32'(exp_edges));
        check_eq({tag, ".result"},  32'(result), 32'(exp_res));
        check_eq({tag, ".busy_op"}, 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        req[t] = 1'b0;
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".idle_done"}, 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic saw_done;

        reset = 1'b1;
        req   = '0;
        op    = '0;
        rs    = '0;
        rt    = '0;
        #12;
        check_eq("reset.done",   32'(done),   32'd0);
        check_eq("reset.result", 32'(result), 32'd0);
        check_eq("reset.busy",   32'(busy),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single thread, quotient then remainder: 100/7 = 14 r 2.
        set_thread(1, 1'b0, 8'd100, 8'd7);
        wait_done("t1_q", 1, EDGES_FULL, 8'd14);
        set_thread(1, 1'b1, 8'd100, 8'd7);
        wait_done("t1_r", 1, EDGES_FULL, 8'd2);

        // Divide by zero: quotient all ones, remainder = dividend.
        set_thread(0, 1'b0, 8'd55, 8'd0);
        wait_done("dz_q", 0, EDGES_EO, 8'd255);
        set_thread(0, 1'b1, 8'd55, 8'd0);
        wait_done("dz_r", 0, EDGES_EO, 8'd55);

        // All four at once from rr_ptr=0: served 0,1,2,3 with one IDLE gap each.
        do_reset();
        set_thread(0, 1'b0, 8'd200, 8'd3);    // 66 r 2
        set_thread(1, 1'b1, 8'd250, 8'd16);   // 15 r 10
        set_thread(2, 1'b0, 8'd77,  8'd77);   // 1 r 0
        set_thread(3, 1'b1, 8'd9,   8'd200);  // 0 r 9
        wait_done("all_t0", 0, EDGES_FULL, 8'd66);
        wait_done("all_t1", 1, EDGES_FULL, 8'd10);
        wait_done("all_t2", 2, EDGES_FULL, 8'd1);
        wait_done("all_t3", 3, EDGES_EO,   8'd9);

        // Thread 2 wins alone, then 0 and 3 request: rotation from 3 serves 3 first.
        set_thread(2, 1'b0, 8'd255, 8'd1);
        @(posedge clk);
        #1;
        set_thread(0, 1'b0, 8'd81,  8'd9);    // 9 r 0
        set_thread(3, 1'b1, 8'd143, 8'd12);   // 11 r 11
        wait_done("rot_t2", 2, EDGES_FULL - 1, 8'd255);
        wait_done("rot_t3", 3, EDGES_FULL, 8'd11);
        wait_done("rot_t0", 0, EDGES_FULL, 8'd9);

        // Reset during ITERATE cycle 4 of thread 2 (rr_ptr is 1 at this point).
        set_thread(2, 1'b0, 8'd99, 8'd4);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid.busy_reset", 32'(busy), 32'd0);
        check_eq("mid.done_reset", 32'(done), 32'd0);
        req[2]   = 1'b0;
        saw_done = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done != '0) saw_done = 1'b1;
        end
        check_eq("mid.no_done", 32'(saw_done), 32'd0);
        // rr_ptr back to 0 means thread 0 beats thread 2.
        set_thread(0, 1'b1, 8'd60, 8'd7);     // 8 r 4
        set_thread(2, 1'b0, 8'd99, 8'd4);     // 24 r 3
        wait_done("post_t0", 0, EDGES_FULL, 8'd4);
        wait_done("post_t2", 2, EDGES_FULL, 8'd24);

        // Small dividend (early-out candidate) and a full-path divide.
        set_thread(1, 1'b0, 8'd3, 8'd9);
        wait_done("eo_q", 1, EDGES_EO, 8'd0);
        set_thread(1, 1'b1, 8'd3, 8'd9);
        wait_done("eo_r", 1, EDGES_EO, 8'd3);
        set_thread(3, 1'b0, 8'd200, 8'd3);
        wait_done("full_q", 3, EDGES_FULL, 8'd66);
        set_thread(3, 1'b1, 8'd200, 8'd3);
        wait_done("full_r", 3, EDGES_FULL, 8'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
